// File: rtl/spi_sync_bridge.sv
// spi_sync_bridge: system-clock companion to the SPI slave core.
// Brings the core's sclk-domain strobes and ssel into clk, captures
// received words, and stages the next transmit word in a single-entry
// pending register with a txWr/txReady handshake.
// Build option: define SPI_BRIDGE_CNT_EN to add the saturating
// rxCount/urCount statistics counters. Without it both read as 0.
module spi_sync_bridge #(
  parameter int unsigned         DATA_WDT = 8,
  parameter logic [DATA_WDT-1:0] TX_IDLE  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spiSsel,
  input  logic                spiTxLoadFirst,
  input  logic                spiTxLoadFollow,
  output logic [DATA_WDT-1:0] spiTxData,
  input  logic                spiRxRdy,
  input  logic [DATA_WDT-1:0] spiRxData,
  input  logic [DATA_WDT-1:0] txWord,
  input  logic                txWr,
  output logic                txReady,
  output logic [DATA_WDT-1:0] rxWord,
  output logic                rxValid,
  output logic                csStart,
  output logic                csStop,
  output logic                txUnderrun,
  output logic [15:0]         rxCount,
  output logic [15:0]         urCount
);

  // Each vector is {s3, s2, s1}; s1/s2 resolve metastability, s3 is history.
  logic [2:0] sselSync;
  logic [2:0] rxRdySync;
  logic [2:0] loadFirstSync;
  logic [2:0] loadFollowSync;

  logic                sselS2;
  logic                sselFall;
  logic                sselRise;
  logic                rxRdyFall;
  logic                loadEdge;

  logic [DATA_WDT-1:0] pending;
  logic                pendFull;
  logic                armed;

  // Synchronizer chains, reset to the idle level of each line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sselSync       <= 3'b111;
      rxRdySync      <= 3'b000;
      loadFirstSync  <= 3'b000;
      loadFollowSync <= 3'b000;
    end else begin
      sselSync       <= {sselSync[1:0], spiSsel};
      rxRdySync      <= {rxRdySync[1:0], spiRxRdy};
      loadFirstSync  <= {loadFirstSync[1:0], spiTxLoadFirst};
      loadFollowSync <= {loadFollowSync[1:0], spiTxLoadFollow};
    end
  end

  assign sselS2    = sselSync[1];
  assign sselFall  = sselSync[2] & ~sselSync[1];
  assign sselRise  = ~sselSync[2] & sselSync[1];
  assign rxRdyFall = rxRdySync[2] & ~rxRdySync[1];
  assign loadEdge  = (loadFirstSync[1] & ~loadFirstSync[2]) |
                     (loadFollowSync[1] & ~loadFollowSync[2]);

  assign txReady = ~pendFull;

  // Frame pulses and receive capture; an rxRdy fall seen while ssel is
  // already high comes from the core being reset by ssel and is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csStart <= 1'b0;
      csStop  <= 1'b0;
      rxValid <= 1'b0;
      rxWord  <= '0;
    end else begin
      csStart <= sselFall;
      csStop  <= sselRise;
      rxValid <= rxRdyFall & ~sselS2;
      if (rxRdyFall && !sselS2) begin
        rxWord <= spiRxData;
      end
    end
  end

  // Transmit staging: a load consumes the pending word or falls back to
  // TX_IDLE with an underrun; while idle, a pending word is pushed to the
  // core early so the first word of the next frame is already in place.
  // The write is resolved last so a same-cycle load sees the old state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spiTxData  <= TX_IDLE;
      pending    <= '0;
      pendFull   <= 1'b0;
      armed      <= 1'b0;
      txUnderrun <= 1'b0;
    end else begin
      txUnderrun <= 1'b0;
      if (sselRise && !armed) begin
        spiTxData <= TX_IDLE;
      end
      if (loadEdge) begin
        if (pendFull) begin
          spiTxData <= pending;
          armed     <= 1'b1;
          pendFull  <= 1'b0;
        end else begin
          spiTxData  <= TX_IDLE;
          armed      <= 1'b0;
          txUnderrun <= 1'b1;
        end
      end else if (sselS2 && !armed && pendFull) begin
        spiTxData <= pending;
        armed     <= 1'b1;
        pendFull  <= 1'b0;
      end
      if (txWr && !pendFull) begin
        pending  <= txWord;
        pendFull <= 1'b1;
      end
    end
  end

`ifdef SPI_BRIDGE_CNT_EN
  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxCount <= '0;
      urCount <= '0;
    end else begin
      if (rxValid && rxCount != 16'hFFFF) begin
        rxCount <= rxCount + 16'd1;
      end
      if (txUnderrun && urCount != 16'hFFFF) begin
        urCount <= urCount + 16'd1;
      end
    end
  end
`else
  assign rxCount = '0;
  assign urCount = '0;
`endif

endmodule

// File: tb/tb_spi_sync_bridge.sv
// Testbench for spi_sync_bridge: plays the SPI core side (ssel, load and
// rxRdy strobes) and the system side (txWr), predicting every output from
// a transaction-level model of the bridge's transmit/receive rules.
module tb_spi_sync_bridge;

  localparam int unsigned DW   = 8;
  localparam logic [7:0]  IDLE = 8'hE7;
`ifdef SPI_BRIDGE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          spiSsel = 1'b1;
  logic          spiTxLoadFirst = 1'b0;
  logic          spiTxLoadFollow = 1'b0;
  logic [DW-1:0] spiTxData;
  logic          spiRxRdy = 1'b0;
  logic [DW-1:0] spiRxData = '0;
  logic [DW-1:0] txWord = '0;
  logic          txWr = 1'b0;
  logic          txReady;
  logic [DW-1:0] rxWord;
  logic          rxValid;
  logic          csStart;
  logic          csStop;
  logic          txUnderrun;
  logic [15:0]   rxCount;
  logic [15:0]   urCount;

  spi_sync_bridge #(.DATA_WDT(DW), .TX_IDLE(IDLE)) dut (
    .clk(clk), .reset(reset), .spiSsel(spiSsel),
    .spiTxLoadFirst(spiTxLoadFirst), .spiTxLoadFollow(spiTxLoadFollow),
    .spiTxData(spiTxData), .spiRxRdy(spiRxRdy), .spiRxData(spiRxData),
    .txWord(txWord), .txWr(txWr), .txReady(txReady), .rxWord(rxWord),
    .rxValid(rxValid), .csStart(csStart), .csStop(csStop),
    .txUnderrun(txUnderrun), .rxCount(rxCount), .urCount(urCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observed pulse totals, sampled shortly after each rising edge.
  int cRx = 0, cUr = 0, cStart = 0, cStop = 0;
  always @(posedge clk) begin
    #1;
    if (rxValid)    cRx++;
    if (txUnderrun) cUr++;
    if (csStart)    cStart++;
    if (csStop)     cStop++;
  end

  // Reference model: pending slot, word currently offered to the core,
  // whether that word is still unconsumed, and expected event totals.
  logic [7:0] mPend = '0;
  bit         mPendFull = 1'b0;
  bit         mArmed = 1'b0;
  logic [7:0] mTx = IDLE;
  bit         mIdle = 1'b1;
  int         mRx = 0, mUr = 0, mStart = 0, mStop = 0;
  int         hwRx = 0, hwUr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void modelIdlePush();
    if (mIdle && !mArmed && mPendFull) begin
      mTx = mPend; mArmed = 1'b1; mPendFull = 1'b0;
    end
  endfunction

  function automatic void modelStop();
    mIdle = 1'b1;
    mStop++;
    if (!mArmed) mTx = IDLE;
    modelIdlePush();
  endfunction

  task automatic checkTx(input string tag);
    check({tag, "_txdata"}, 32'(spiTxData), 32'(mTx));
    check({tag, "_txready"}, 32'(txReady), 32'(!mPendFull));
  endtask

  task automatic writeTx(input logic [7:0] w);
    txWord = w; txWr = 1'b1;
    @(negedge clk);
    txWr = 1'b0;
    if (!mPendFull) begin mPend = w; mPendFull = 1'b1; end
    modelIdlePush();
    tick(2);
    checkTx("write");
  endtask

  task automatic frameStart();
    spiSsel = 1'b0; mIdle = 1'b0; mStart++;
    tick(5);
    check("cs_start_count", 32'(cStart), 32'(mStart));
    checkTx("start");
  endtask

  task automatic frameStop();
    spiSsel = 1'b1;
    modelStop();
    tick(5);
    check("cs_stop_count", 32'(cStop), 32'(mStop));
    checkTx("stop");
  endtask

  // Core takes spiTxData and raises a load strobe; rd is what it shifted out.
  task automatic loadWord(input bit first, output logic [7:0] rd);
    rd = spiTxData;
    check("master_read", 32'(rd), 32'(mTx));
    if (first) spiTxLoadFirst = 1'b1; else spiTxLoadFollow = 1'b1;
    if (mPendFull) begin
      mTx = mPend; mArmed = 1'b1; mPendFull = 1'b0;
    end else begin
      mTx = IDLE; mArmed = 1'b0; mUr++; hwUr++;
    end
    tick(4);
    spiTxLoadFirst = 1'b0; spiTxLoadFollow = 1'b0;
    tick(2);
    check("underrun_count", 32'(cUr), 32'(mUr));
    checkTx("load");
  endtask

  // Word received: rxRdy falls, rxValid must appear on the 3rd edge only.
  task automatic rxWordIn(input logic [7:0] w);
    spiRxRdy = 1'b1;
    tick(3);
    spiRxData = w; spiRxRdy = 1'b0;
    tick(2);
    check("rx_valid_early", 32'(rxValid), 32'd0);
    tick(1);
    check("rx_valid_edge3", 32'(rxValid), 32'd1);
    check("rx_word", 32'(rxWord), 32'(w));
    tick(1);
    check("rx_valid_width", 32'(rxValid), 32'd0);
    mRx++; hwRx++;
    tick(2);
    check("rx_count_pulses", 32'(cRx), 32'(mRx));
  endtask

  // ssel rises in the same cycle the core's rxRdy drops: word is discarded.
  task automatic rxAbort(input logic [7:0] w);
    spiRxRdy = 1'b1;
    tick(3);
    spiRxData = w; spiRxRdy = 1'b0; spiSsel = 1'b1;
    modelStop();
    tick(6);
    check("abort_no_rx", 32'(cRx), 32'(mRx));
    check("abort_cs_stop", 32'(cStop), 32'(mStop));
    checkTx("abort");
  endtask

  task automatic checkCounters(input string tag);
    check({tag, "_rxcount"}, 32'(rxCount), CNT_EN ? 32'(hwRx) : 32'd0);
    check({tag, "_urcount"}, 32'(urCount), CNT_EN ? 32'(hwUr) : 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    int nW;

    tick(3);
    check("rst_txdata", 32'(spiTxData), 32'(IDLE));
    check("rst_txready", 32'(txReady), 32'd1);
    check("rst_rxword", 32'(rxWord), 32'd0);
    check("rst_pulses", 32'({rxValid, csStart, csStop, txUnderrun}), 32'd0);
    checkCounters("rst");
    reset = 1'b1;
    tick(4);
    check("post_rst_pulses", 32'(cRx + cUr + cStart + cStop), 32'd0);

    // Idle preload, then a two-word frame in both directions.
    writeTx(8'hA5);
    check("preload_a5", 32'(spiTxData), 32'hA5);
    frameStart();
    check("single_cs_start", 32'(cStart), 32'd1);
    check("ready_before_sclk", 32'(txReady), 32'd1);
    loadWord(1'b1, rd);
    check("read_a5", 32'(rd), 32'hA5);
    rxWordIn(8'h3C);
    loadWord(1'b0, rd);
    rxWordIn(8'hC3);
    frameStop();

    // One written word, three-word frame: the rest is TX_IDLE.
    writeTx(8'h11);
    frameStart();
    loadWord(1'b1, rd);
    check("read_11", 32'(rd), 32'h11);
    loadWord(1'b0, rd);
    check("read_idle_a", 32'(rd), 32'(IDLE));
    loadWord(1'b0, rd);
    check("read_idle_b", 32'(rd), 32'(IDLE));
    frameStop();
    checkCounters("after_underrun");

    // Frame cut short mid-word, then a clean frame.
    frameStart();
    loadWord(1'b1, rd);
    rxAbort(8'h5B);
    frameStart();
    loadWord(1'b1, rd);
    rxWordIn(8'h96);
    frameStop();

    // Write while not ready is dropped; the staged word survives.
    writeTx(8'h22);
    writeTx(8'h55);
    check("busy_not_ready", 32'(txReady), 32'd0);
    writeTx(8'h77);
    frameStart();
    loadWord(1'b1, rd);
    check("read_22", 32'(rd), 32'h22);
    loadWord(1'b0, rd);
    check("read_55_not_77", 32'(rd), 32'h55);
    frameStop();
    checkCounters("mid");

    // Asynchronous reset in the middle of a word.
    writeTx(8'h3D);
    frameStart();
    spiRxRdy = 1'b1;
    spiRxData = 8'hF0;
    tick(2);
    #2 reset = 1'b0;
    #1;
    check("arst_txdata", 32'(spiTxData), 32'(IDLE));
    check("arst_txready", 32'(txReady), 32'd1);
    check("arst_rxword", 32'(rxWord), 32'd0);
    spiSsel = 1'b1; spiRxRdy = 1'b0;
    mPendFull = 1'b0; mArmed = 1'b0; mTx = IDLE; mIdle = 1'b1;
    hwRx = 0; hwUr = 0;
    tick(2);
    checkCounters("arst");
    reset = 1'b1;
    tick(6);
    check("arst_no_rx", 32'(cRx), 32'(mRx));
    check("arst_no_start", 32'(cStart), 32'(mStart));
    check("arst_no_stop", 32'(cStop), 32'(mStop));
    check("arst_no_ur", 32'(cUr), 32'(mUr));
    frameStart();
    loadWord(1'b1, rd);
    rxWordIn(8'h81);
    frameStop();

    // Randomized frames.
    for (int it = 0; it < 20; it++) begin
      for (int p = 0; p < int'($urandom_range(0, 2)); p++) writeTx(8'($urandom));
      frameStart();
      nW = int'($urandom_range(1, 3));
      for (int k = 0; k < nW; k++) begin
        if ($urandom_range(0, 1) == 1) writeTx(8'($urandom));
        loadWord(k == 0, rd);
        if (k == nW - 1 && $urandom_range(0, 4) == 0) rxAbort(8'($urandom));
        else rxWordIn(8'($urandom));
      end
      if (!mIdle) frameStop();
    end
    checkCounters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
